// File: rtl/board_clock_pkg.sv
// Shared types and constants for the board clock-enable generator.
// Ratio constants are NUM/DEN pairs against the 107.4 MHz base clock.
package board_clock_pkg;

    localparam int unsigned ACC_WIDTH_DEFAULT = 16;
    localparam int unsigned CH_COUNT_DEFAULT  = 4;

    typedef struct packed {
        logic [ACC_WIDTH_DEFAULT-1:0] num;
        logic [ACC_WIDTH_DEFAULT-1:0] den;
        logic                         en;
    } ce_cfg_t;

    localparam ce_cfg_t RATIO_21M = '{
        num: ACC_WIDTH_DEFAULT'(1),
        den: ACC_WIDTH_DEFAULT'(5),
        en:  1'b1
    };

    localparam ce_cfg_t RATIO_3M58 = '{
        num: ACC_WIDTH_DEFAULT'(1),
        den: ACC_WIDTH_DEFAULT'(30),
        en:  1'b1
    };

    localparam ce_cfg_t RATIO_TMDS_P = '{
        num: ACC_WIDTH_DEFAULT'(1),
        den: ACC_WIDTH_DEFAULT'(5),
        en:  1'b1
    };

endpackage

// File: rtl/board_ce_channel.sv
// One fractional clock-enable channel: phase accumulator, config registers,
// registered CE strobe and RUNNING flag.
module board_ce_channel
    import board_clock_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ready,
    input  logic                 clear,
    input  logic                 cfg_we,
    input  logic [ACC_WIDTH-1:0] cfg_num,
    input  logic [ACC_WIDTH-1:0] cfg_den,
    input  logic                 cfg_en,
    output logic                 ce,
    output logic                 running
);

    logic [ACC_WIDTH-1:0] num_q, num_d;
    logic [ACC_WIDTH-1:0] den_q, den_d;
    logic                 en_q, en_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ce_q, ce_d;
    logic                 running_q, running_d;

    logic [ACC_WIDTH-1:0] num_eff;
    logic [ACC_WIDTH:0]   sum;
    logic                 wrap;
    logic                 active;

    always_comb begin
        num_eff   = (num_q > den_q) ? den_q : num_q;
        // One extra bit so ACC + NUMe never overflows before the compare.
        sum       = {1'b0, acc_q} + {1'b0, num_eff};
        wrap      = (sum >= {1'b0, den_q});
        active    = ready && en_q && (den_q != '0);

        num_d     = num_q;
        den_d     = den_q;
        en_d      = en_q;
        acc_d     = acc_q;
        ce_d      = 1'b0;

        if (cfg_we) begin
            num_d = cfg_num;
            den_d = cfg_den;
            en_d  = cfg_en;
            acc_d = '0;
        end else if (clear || !active) begin
            acc_d = '0;
        end else if (wrap) begin
            // True result is below DEN, so modular subtraction is exact.
            acc_d = sum[ACC_WIDTH-1:0] - den_q;
            ce_d  = 1'b1;
        end else begin
            acc_d = sum[ACC_WIDTH-1:0];
        end

        // Reflects the config in force after this edge.
        running_d = ready && en_d && (den_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q     <= '0;
            den_q     <= '0;
            en_q      <= 1'b0;
            acc_q     <= '0;
            ce_q      <= 1'b0;
            running_q <= 1'b0;
        end else begin
            num_q     <= num_d;
            den_q     <= den_d;
            en_q      <= en_d;
            acc_q     <= acc_d;
            ce_q      <= ce_d;
            running_q <= running_d;
        end
    end

    assign ce      = ce_q;
    assign running = running_q;

endmodule

// File: rtl/board_clock_enable_gen.sv
// Multi-channel fractional clock-enable generator on the board base clock.
// Decodes config writes per channel and fans out SYNC and READY.
module board_clock_enable_gen
    import board_clock_pkg::*;
#(
    parameter int unsigned CH_COUNT  = CH_COUNT_DEFAULT,
    parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEFAULT,
    parameter int unsigned CH_BITS   = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1
) (
    input  logic                 CLK,
    input  logic                 RESET_n,
    input  logic                 READY,
    input  logic                 CFG_WE,
    input  logic [CH_BITS-1:0]   CFG_CH,
    input  logic [ACC_WIDTH-1:0] CFG_NUM,
    input  logic [ACC_WIDTH-1:0] CFG_DEN,
    input  logic                 CFG_EN,
    input  logic                 SYNC,
    output logic [CH_COUNT-1:0]  CE,
    output logic [CH_COUNT-1:0]  RUNNING
);

    logic [CH_COUNT-1:0] ch_we;

    // Out-of-range channel numbers match no channel and are dropped.
    always_comb begin
        ch_we = '0;
        for (int i = 0; i < CH_COUNT; i++) begin
            ch_we[i] = CFG_WE && (32'(CFG_CH) == 32'(i));
        end
    end

    for (genvar g = 0; g < CH_COUNT; g++) begin : g_ch
        board_ce_channel #(
            .ACC_WIDTH (ACC_WIDTH)
        ) u_ch (
            .clk     (CLK),
            .rst_n   (RESET_n),
            .ready   (READY),
            .clear   (SYNC),
            .cfg_we  (ch_we[g]),
            .cfg_num (CFG_NUM),
            .cfg_den (CFG_DEN),
            .cfg_en  (CFG_EN),
            .ce      (CE[g]),
            .running (RUNNING[g])
        );
    end

endmodule

// File: tb/tb_board_clock_enable_gen.sv
// Directed bench for board_clock_enable_gen: ratios, SYNC, READY gating,
// invalid channel writes and asynchronous reset.
module tb_board_clock_enable_gen;
    import board_clock_pkg::*;

    logic        CLK;
    logic        RESET_n;
    logic        READY;
    logic        CFG_WE;
    logic [2:0]  CFG_CH;
    logic [15:0] CFG_NUM;
    logic [15:0] CFG_DEN;
    logic        CFG_EN;
    logic        SYNC;
    logic [3:0]  CE;
    logic [3:0]  RUNNING;

    int tests = 0;
    int fails = 0;

    // CH_BITS widened so that CFG_CH = CH_COUNT is representable.
    board_clock_enable_gen #(
        .CH_COUNT  (4),
        .ACC_WIDTH (16),
        .CH_BITS   (3)
    ) dut (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .READY   (READY),
        .CFG_WE  (CFG_WE),
        .CFG_CH  (CFG_CH),
        .CFG_NUM (CFG_NUM),
        .CFG_DEN (CFG_DEN),
        .CFG_EN  (CFG_EN),
        .SYNC    (SYNC),
        .CE      (CE),
        .RUNNING (RUNNING)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_cfg(input int ch, input logic [15:0] num, input logic [15:0] den,
                             input logic en);
        CFG_WE  = 1'b1;
        CFG_CH  = 3'(ch);
        CFG_NUM = num;
        CFG_DEN = den;
        CFG_EN  = en;
        step();
        CFG_WE  = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_ce;
        int bad;
        int c0, c1, c2, c3;

        RESET_n = 1'b0;
        READY   = 1'b0;
        CFG_WE  = 1'b0;
        CFG_CH  = '0;
        CFG_NUM = '0;
        CFG_DEN = '0;
        CFG_EN  = 1'b0;
        SYNC    = 1'b0;
        #12;
        check("reset_ce", CE, 4'h0);
        check("reset_running", RUNNING, 4'h0);
        step();
        RESET_n = 1'b1;
        READY   = 1'b1;
        step();
        check("idle_running", RUNNING, 4'h0);

        // Program all channels at different phases, then align with SYNC.
        write_cfg(0, RATIO_21M.num, RATIO_21M.den, 1'b1);
        check("wr0_running", RUNNING, 4'b0001);
        write_cfg(1, 16'd2, 16'd5, 1'b1);
        write_cfg(2, RATIO_3M58.num, RATIO_3M58.den, 1'b1);
        write_cfg(3, 16'd7, 16'd5, 1'b1);
        check("wr3_ce", CE, 4'h0);
        check("wr3_running", RUNNING, 4'hf);
        SYNC = 1'b1;
        step();
        SYNC = 1'b0;
        check("sync_ce", CE, 4'h0);
        check("sync_running", RUNNING, 4'hf);

        bad = 0; c0 = 0; c1 = 0; c2 = 0; c3 = 0;
        for (int k = 1; k <= 1000; k++) begin
            step();
            exp_ce[0] = (k % 5 == 0);
            exp_ce[1] = (k % 5 == 3) || (k % 5 == 0);
            exp_ce[2] = (k % 30 == 0);
            exp_ce[3] = 1'b1;
            if (CE !== exp_ce) bad++;
            c0 += int'(CE[0]);
            c1 += int'(CE[1]);
            c2 += int'(CE[2]);
            c3 += int'(CE[3]);
            if (k == 3)  check("run_e3", CE, 4'b1010);
            if (k == 5)  check("run_e5", CE, 4'b1011);
            if (k == 30) check("run_e30", CE, 4'b1111);
        end
        check("ce_pattern_errs", bad, 0);
        check("cnt_ch0", c0, 200);
        check("cnt_ch1", c1, 400);
        check("cnt_ch2", c2, 33);
        check("cnt_ch3", c3, 1000);

        // Re-align mid-run.
        step();
        step();
        SYNC = 1'b1;
        step();
        SYNC = 1'b0;
        check("resync_ce", CE, 4'h0);
        check("resync_running", RUNNING, 4'hf);
        c0 = 0; c2 = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            c0 += int'(CE[0]);
            c2 += int'(CE[2]);
            if (k == 1)  check("resync_e1", CE, 4'b1000);
            if (k == 30) check("resync_e30", CE, 4'b1111);
        end
        check("resync_cnt0", c0, 6);
        check("resync_cnt2", c2, 1);

        // READY low for three cycles.
        READY = 1'b0;
        step();
        check("rdy_lo_ce", CE, 4'h0);
        check("rdy_lo_running", RUNNING, 4'h0);
        step();
        step();
        check("rdy_lo3_running", RUNNING, 4'h0);
        READY = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) check("rdy_e1_ce", CE, 4'b1000);
            if (k == 1) check("rdy_e1_running", RUNNING, 4'hf);
            if (k == 4) check("rdy_e4_ce", CE, 4'b1000);
            if (k == 5) check("rdy_e5_ce", CE, 4'b1011);
        end

        // DEN = 0 stops channel 0.
        write_cfg(0, 16'd1, 16'd0, 1'b1);
        check("den0_running", RUNNING, 4'b1110);
        c0 = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            c0 += int'(CE[0]);
        end
        check("den0_cnt0", c0, 0);

        // Out-of-range channel numbers are ignored.
        write_cfg(4, 16'd1, 16'd1, 1'b1);
        check("inv4_running", RUNNING, 4'b1110);
        write_cfg(7, 16'd0, 16'd0, 1'b0);
        check("inv7_running", RUNNING, 4'b1110);
        check("inv7_ce3", CE[3], 1'b1);

        // NUM = 0: running but never strobes.
        write_cfg(2, 16'd0, 16'd7, 1'b1);
        check("num0_running", RUNNING, 4'b1110);
        c2 = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            c2 += int'(CE[2]);
        end
        check("num0_cnt2", c2, 0);

        // Asynchronous reset while ch3 is strobing.
        check("pre_rst_ce3", CE[3], 1'b1);
        RESET_n = 1'b0;
        #1;
        check("async_rst_ce", CE, 4'h0);
        check("async_rst_running", RUNNING, 4'h0);
        #2;
        RESET_n = 1'b1;
        step();
        step();
        check("post_rst_ce", CE, 4'h0);
        check("post_rst_running", RUNNING, 4'h0);

        // Write and SYNC in the same cycle.
        SYNC = 1'b1;
        write_cfg(0, RATIO_TMDS_P.num, RATIO_TMDS_P.den, 1'b1);
        SYNC = 1'b0;
        check("wrsync_running", RUNNING, 4'b0001);
        check("wrsync_ce", CE, 4'h0);
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 4) check("wrsync_e4", CE, 4'h0);
            if (k == 5) check("wrsync_e5", CE, 4'b0001);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
